// File: rtl/submodulo_2_pkg.sv
// Shared types and default timing for the lighting-system push-button blocks.
// Defaults assume a 1 kHz clock.
package submodulo_2_pkg;

    typedef enum logic [1:0] {
        SOLTO    = 2'd0,
        CONTANDO = 2'd1,
        LONGO    = 2'd2
    } estado_t;

    localparam int DEBOUNCE_CYC_DEF = 50;
    localparam int T_MIN_CYC_DEF    = 300;
    localparam int T_LONG_CYC_DEF   = 5000;

endpackage

// File: rtl/submodulo_2_debounce.sv
// Two-flop synchronizer followed by a stable-count filter.
// The filtered level only moves after the synced input differs from it for DEBOUNCE_CYC cycles.
module submodulo_2_debounce
    import submodulo_2_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic din_i,
    output logic level_o
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The cycle that would bring the count to DEBOUNCE_CYC commits the new level instead.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/submodulo_2.sv
// Push-button press classifier: long-press strobe a (held T_LONG_CYC cycles) and
// short-press strobe b (released after more than T_MIN_CYC but fewer than T_LONG_CYC cycles).
module submodulo_2
    import submodulo_2_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int T_MIN_CYC    = T_MIN_CYC_DEF,
    parameter int T_LONG_CYC   = T_LONG_CYC_DEF,
    parameter int CNT_W        = $clog2(T_LONG_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    output logic a,
    output logic b,
    output logic pressionado
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(T_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(T_MIN_CYC);

    logic             filt;
    logic             lvl_q;
    estado_t          state_q;
    estado_t          state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             a_q;
    logic             a_d;
    logic             b_q;
    logic             b_d;

    submodulo_2_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk_i  (clk),
        .rst_ni (rst),
        .din_i  (botao),
        .level_o(filt)
    );

    // The FSM times the registered level so a lands exactly T_LONG_CYC cycles after pressionado rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q   <= 1'b0;
            state_q <= SOLTO;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            lvl_q   <= filt;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            SOLTO: begin
                if (lvl_q) begin
                    state_d = CONTANDO;
                    cnt_d   = CNT_W'(1);
                end
            end
            CONTANDO: begin
                if (!lvl_q) begin
                    state_d = SOLTO;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONGO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LONGO: begin
                if (!lvl_q) begin
                    state_d = SOLTO;
                end
            end
            default: begin
                state_d = SOLTO;
            end
        endcase
    end

    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        case (state_q)
            CONTANDO: begin
                if (lvl_q) begin
                    a_d = (cnt_q == LONG_LAST);
                end else begin
                    b_d = (cnt_q > MIN_CNT) && (cnt_q <= LONG_LAST);
                end
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
    end

    assign a           = a_q;
    assign b           = b_q;
    assign pressionado = lvl_q;

endmodule

// File: tb/tb_submodulo_2.sv
// Self-checking bench for submodulo_2: directed press scenarios plus randomized presses,
// compared cycle by cycle against a run-length reference model.
module tb_submodulo_2;

    localparam int DEB   = 4;
    localparam int TMIN  = 30;
    localparam int TLONG = 500;

    logic clk = 1'b0;
    logic rst;
    logic botao;
    logic a;
    logic b;
    logic pressionado;

    always #5 clk = ~clk;

    submodulo_2 #(
        .DEBOUNCE_CYC(DEB),
        .T_MIN_CYC   (TMIN),
        .T_LONG_CYC  (TLONG)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .botao      (botao),
        .a          (a),
        .b          (b),
        .pressionado(pressionado)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw samples since reset, the filtered level, and run lengths of pressionado.
    bit hist[$];
    bit m_filt = 1'b0;
    bit exp_p  = 1'b0;
    bit exp_a  = 1'b0;
    bit exp_b  = 1'b0;
    int len1   = 0;
    int len2   = 0;
    int k;
    bit flip;

    function automatic bit hv(input int idx);
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            hist.delete();
            m_filt = 1'b0;
            exp_p  = 1'b0;
            exp_a  = 1'b0;
            exp_b  = 1'b0;
            len1   = 0;
            len2   = 0;
        end else begin
            hist.push_back(botao);
            k     = hist.size() - 1;
            exp_p = m_filt;
            // Level flips once the synced input has disagreed for DEB consecutive evaluations.
            flip = 1'b1;
            for (int j = k - 1 - DEB; j <= k - 2; j++) begin
                if (hv(j) == m_filt) flip = 1'b0;
            end
            if (flip) m_filt = !m_filt;
            exp_a = (len1 == TLONG);
            exp_b = (len1 == 0) && (len2 > TMIN) && (len2 < TLONG);
            len2  = len1;
            len1  = exp_p ? len1 + 1 : 0;
        end
    end

    int  na = 0;
    int  nb = 0;
    int  nrise = 0;
    logic p_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_p", pressionado, 0);
            check("rst_a", a, 0);
            check("rst_b", b, 0);
        end else begin
            check("pressionado", pressionado, exp_p);
            check("a", a, exp_a);
            check("b", b, exp_b);
        end
        check("ab_excl", a & b, 0);
        if (a === 1'b1) na++;
        if (b === 1'b1) nb++;
        if (pressionado === 1'b1 && p_last === 1'b0) nrise++;
        p_last = pressionado;
    end

    task automatic hold(input bit v, input int n);
        botao = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int len, input int e_a, input int e_b, input string tag);
        int a0;
        int b0;
        a0 = na;
        b0 = nb;
        hold(1'b1, len);
        hold(1'b0, 60);
        check({tag, "_a"}, na - a0, e_a);
        check({tag, "_b"}, nb - b0, e_b);
    endtask

    initial begin
        int a0;
        int b0;
        int r0;
        int l;
        rst   = 1'b0;
        botao = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        hold(1'b0, 20);

        press(100, 0, 1, "short100");
        press(700, 1, 0, "long700");
        press(20,  0, 0, "p20");
        press(30,  0, 0, "p30");
        press(31,  0, 1, "p31");
        press(499, 0, 1, "p499");
        press(500, 1, 0, "p500");

        r0 = nrise;
        a0 = na;
        b0 = nb;
        repeat (5) begin
            hold(1'b1, 2);
            hold(1'b0, 2);
        end
        hold(1'b1, 100);
        hold(1'b0, 60);
        check("bounce_rise", nrise - r0, 1);
        check("bounce_b", nb - b0, 1);
        check("bounce_a", na - a0, 0);

        a0 = na;
        b0 = nb;
        hold(1'b1, 206);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_imm_p", pressionado, 0);
        check("rst_imm_a", a, 0);
        check("rst_imm_b", b, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        hold(1'b1, 600);
        check("rst_press_a", na - a0, 1);
        hold(1'b0, 60);
        check("rst_press_b", nb - b0, 0);

        repeat (12) begin
            if ($urandom_range(0, 1) == 1) begin
                hold(1'b1, $urandom_range(1, 3));
                hold(1'b0, $urandom_range(1, 5));
            end
            l = $urandom_range(1, 700);
            hold(1'b1, l);
            if ($urandom_range(0, 1) == 1) begin
                hold(1'b0, $urandom_range(1, 3));
                hold(1'b1, $urandom_range(1, 200));
            end
            hold(1'b0, 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
